// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive pair: FSM states, parity modes,
// default baud divisor and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // 50 MHz / 9600 baud
    localparam int BPS_CNT_DEFAULT = 5208;

    function automatic logic parity_bit(input logic [7:0] d, input int mode);
        parity_bit = (mode == PAR_ODD) ? ~(^d) : ^d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head word is presented combinationally
// on rd_data while the FIFO is non-empty. Writes while full and reads while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr, do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + 1'b1;
            if (do_rd) rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem_q[rptr_q[AW-1:0]];
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: bytes queue in a small FIFO and are framed LSB-first on a
// registered tx line; frames run back-to-back while the FIFO has data.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BPS_CNT    = BPS_CNT_DEFAULT,
    parameter int PARITY     = PAR_NONE,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       fifo_full,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_ovf,
    output logic       tx
);

    localparam int              CW        = $clog2(BPS_CNT);
    localparam logic [CW-1:0]   CNT_MAX   = CW'(BPS_CNT - 1);
    localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          ovf_q;
    logic          pop, done, tc;
    logic          fifo_empty;
    logic [7:0]    fifo_rd_data;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tx_valid),
        .rd_en   (pop),
        .wr_data (tx_data),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign tc = (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        pop     = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                pop   = !fifo_empty;
            end
            ST_START: begin
                if (tc) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end
            end
            ST_DATA: begin
                if (tc) begin
                    cnt_d   = '0;
                    shreg_d = shreg_q >> 1;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tc) begin
                    state_d = ST_STOP;
                    cnt_d   = '0;
                end
            end
            ST_STOP: begin
                // bit_q doubles as the stop-bit counter; it is zero on entry
                if (tc) begin
                    cnt_d = '0;
                    if (bit_q == STOP_LAST) begin
                        done    = 1'b1;
                        bit_d   = '0;
                        state_d = ST_IDLE;
                        pop     = !fifo_empty;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pop) begin
            state_d = ST_START;
            cnt_d   = '0;
            shreg_d = fifo_rd_data;
            par_d   = parity_bit(fifo_rd_data, PARITY);
        end

        // line level is derived from the next state so tx itself can be a flop
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_q | (tx_valid & fifo_full);
        end
    end

    assign tx      = tx_q;
    assign tx_done = done;
    assign tx_busy = (state_q != ST_IDLE) || !fifo_empty;
    assign tx_ovf  = ovf_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (no parity, even, odd, two stop bits) at 16 cycles/bit,
// checked every cycle against a queue-of-line-samples model plus directed sequences.
module tb_uart_tx;

    localparam int BPS   = 16;
    localparam int DEPTH = 4;
    localparam int NI    = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NI-1:0]       tx_valid = '0;
    logic [NI-1:0][7:0]  tx_data  = '0;
    logic [NI-1:0]       fifo_full, tx_busy, tx_done, tx_ovf, tx;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int PAR = (g == 1) ? 2 : (g == 2) ? 1 : 0;
        localparam int STP = (g == 3) ? 2 : 1;
        uart_tx #(
            .BPS_CNT    (BPS),
            .PARITY     (PAR),
            .STOP_BITS  (STP),
            .FIFO_DEPTH (DEPTH)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .tx_valid  (tx_valid[g]),
            .tx_data   (tx_data[g]),
            .fifo_full (fifo_full[g]),
            .tx_busy   (tx_busy[g]),
            .tx_done   (tx_done[g]),
            .tx_ovf    (tx_ovf[g]),
            .tx        (tx[g])
        );
    end

    int par_cfg  [NI] = '{0, 2, 1, 0};
    int stop_cfg [NI] = '{1, 1, 1, 2};

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Reference model: each accepted byte becomes a list of per-cycle line samples
    // ({last_cycle_of_frame, level}); the line plays them out one per clock.
    logic [7:0] fifo_m [NI][$];
    logic [1:0] line_m [NI][$];
    bit m_tx [NI], m_done [NI], m_inf [NI], m_ovf [NI], m_busy [NI], m_full [NI];

    always @(posedge clk) begin
        bit         full_pre;
        logic [7:0] b;
        logic [1:0] s;
        int         nb;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                fifo_m[i].delete();
                line_m[i].delete();
                m_tx[i] = 1'b1; m_done[i] = 1'b0; m_inf[i] = 1'b0; m_ovf[i] = 1'b0;
            end else begin
                full_pre = (fifo_m[i].size() == DEPTH);
                if (line_m[i].size() == 0 && fifo_m[i].size() != 0) begin
                    b  = fifo_m[i].pop_front();
                    nb = 10 + ((par_cfg[i] != 0) ? 1 : 0) + stop_cfg[i] - 1;
                    for (int j = 0; j < nb; j++) begin
                        bit v;
                        if (j == 0)                          v = 1'b0;
                        else if (j <= 8)                     v = b[j-1];
                        else if (j == 9 && par_cfg[i] != 0)  v = (par_cfg[i] == 2) ? ^b : ~(^b);
                        else                                 v = 1'b1;
                        for (int k = 0; k < BPS; k++)
                            line_m[i].push_back({(j == nb - 1 && k == BPS - 1), v});
                    end
                end
                if (tx_valid[i]) begin
                    if (full_pre) m_ovf[i] = 1'b1;
                    else          fifo_m[i].push_back(tx_data[i]);
                end
                if (line_m[i].size() != 0) begin
                    s = line_m[i].pop_front();
                    m_tx[i] = s[0]; m_done[i] = s[1]; m_inf[i] = 1'b1;
                end else begin
                    m_tx[i] = 1'b1; m_done[i] = 1'b0; m_inf[i] = 1'b0;
                end
            end
            m_busy[i] = m_inf[i] || (fifo_m[i].size() != 0);
            m_full[i] = (fifo_m[i].size() == DEPTH);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                check($sformatf("model_tx[%0d]", i),   tx[i],        m_tx[i]);
                check($sformatf("model_done[%0d]", i), tx_done[i],   m_done[i]);
                check($sformatf("model_busy[%0d]", i), tx_busy[i],   m_busy[i]);
                check($sformatf("model_full[%0d]", i), fifo_full[i], m_full[i]);
                check($sformatf("model_ovf[%0d]", i),  tx_ovf[i],    m_ovf[i]);
            end
        end
    end

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic [11:0] pat;   // line level of bit-time n in bit n
        int         nb;
    } vec_t;

    logic [7:0] bd [6];
    logic       samp_tx [1000];
    logic       samp_busy [1000];
    logic       samp_full [1000];
    logic       samp_ovf [1000];

    task automatic wait_idle(input int i);
        int t;
        t = 0;
        while (tx_busy[i] && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("idle_timeout[%0d]", i), tx_busy[i], 0);
    endtask

    // n writes on consecutive edges starting at edge k; sample c is taken after edge k+c
    task automatic run_burst(input int i, input int n, input int span,
                             output int ndone, output int last_done, output int full_seen);
        ndone = 0; last_done = -1; full_seen = 0;
        @(negedge clk);
        tx_valid[i] = 1'b1;
        tx_data[i]  = bd[0];
        for (int c = 0; c <= span; c++) begin
            @(negedge clk);
            if (c < n - 1) tx_data[i] = bd[c+1];
            else           tx_valid[i] = 1'b0;
            samp_tx[c]   = tx[i];
            samp_busy[c] = tx_busy[i];
            samp_full[c] = fifo_full[i];
            samp_ovf[c]  = tx_ovf[i];
            if (tx_done[i]) begin ndone++; last_done = c; end
            if (fifo_full[i]) full_seen++;
        end
    endtask

    initial begin
        vec_t tbl [6];
        int   nd, ld, fs, hi;
        logic [7:0] dec;

        tbl[0] = '{0, 8'h55, 12'h2AA, 10};
        tbl[1] = '{1, 8'h07, 12'h60E, 11};
        tbl[2] = '{2, 8'h07, 12'h40E, 11};
        tbl[3] = '{3, 8'hA5, 12'h74A, 11};
        tbl[4] = '{1, 8'h00, 12'h400, 11};
        tbl[5] = '{2, 8'hFF, 12'h7FE, 11};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_tx[%0d]", i),   tx[i],        1);
            check($sformatf("rst_busy[%0d]", i), tx_busy[i],   0);
            check($sformatf("rst_done[%0d]", i), tx_done[i],   0);
            check($sformatf("rst_full[%0d]", i), fifo_full[i], 0);
            check($sformatf("rst_ovf[%0d]", i),  tx_ovf[i],    0);
        end

        // single-frame vectors
        for (int r = 0; r < 6; r++) begin
            int i, done_at;
            i = tbl[r].inst;
            done_at = -1;
            wait_idle(i);
            @(negedge clk);
            tx_valid[i] = 1'b1;
            tx_data[i]  = tbl[r].data;
            @(negedge clk);
            tx_valid[i] = 1'b0;
            check($sformatf("vec%0d_pre_start", r), tx[i], 1);
            for (int c = 1; c <= tbl[r].nb * BPS; c++) begin
                @(negedge clk);
                if (c == 1) check($sformatf("vec%0d_start_fall", r), tx[i], 0);
                if (c % BPS == 8)
                    check($sformatf("vec%0d_bit%0d", r, c / BPS), tx[i], tbl[r].pat[c / BPS]);
                if (tx_done[i] && done_at < 0) done_at = c;
            end
            check($sformatf("vec%0d_done_cycle", r), done_at, tbl[r].nb * BPS);
            @(negedge clk);
            check($sformatf("vec%0d_busy_fall", r), tx_busy[i], 0);
        end

        // four-byte burst: back-to-back frames, never full
        wait_idle(0);
        bd = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        run_burst(0, 4, 700, nd, ld, fs);
        check("burst_done_count", nd, 4);
        check("burst_last_done", ld, 640);
        check("burst_full_seen", fs, 0);
        check("burst_start", samp_tx[1], 0);
        check("burst_busy_640", samp_busy[640], 1);
        check("burst_busy_641", samp_busy[641], 0);

        // six writes into a depth-4 FIFO: sixth dropped
        wait_idle(0);
        run_burst(0, 6, 850, nd, ld, fs);
        check("ovf_full_at_4", samp_full[4], 1);
        check("ovf_before", samp_ovf[4], 0);
        check("ovf_after", samp_ovf[5], 1);
        check("ovf_done_count", nd, 5);
        check("ovf_last_done", ld, 800);

        // two stop bits, two frames back-to-back
        wait_idle(3);
        bd = '{8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        run_burst(3, 2, 400, nd, ld, fs);
        hi = 0;
        for (int c = 145; c <= 176; c++) hi += samp_tx[c];
        check("stop2_high_cycles", hi, 32);
        check("stop2_next_start", samp_tx[177], 0);
        check("stop2_done_count", nd, 2);
        check("stop2_last_done", ld, 352);

        // reset during data bit 3 (line bit-time 4, cycles 65..80)
        wait_idle(0);
        @(negedge clk);
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'hC3;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        repeat (70) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_tx", tx[0], 1);
        check("rst_mid_busy", tx_busy[0], 0);
        check("rst_mid_full", fifo_full[0], 0);
        check("rst_mid_ovf", tx_ovf[0], 0);
        nd = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (tx_done[0]) nd++;
        end
        check("rst_mid_no_done", nd, 0);
        bd = '{8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_burst(0, 1, 200, nd, ld, fs);
        dec = '0;
        for (int b = 0; b < 8; b++) dec[b] = samp_tx[BPS * (b + 1) + 8];
        check("rst_after_byte", dec, 8'h3C);
        check("rst_after_done", ld, 160);

        // random writes across all instances, checked by the model
        for (int n = 0; n < 80; n++) begin
            int i, gap;
            i   = $urandom_range(0, NI - 1);
            gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60);
            @(negedge clk);
            tx_valid    = '0;
            tx_valid[i] = 1'b1;
            tx_data[i]  = 8'($urandom_range(0, 255));
            if (gap > 0) begin
                @(negedge clk);
                tx_valid = '0;
                repeat (gap - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        tx_valid = '0;
        for (int i = 0; i < NI; i++) wait_idle(i);
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
